rsa_modexp_sched: RTL and testbench

- Scheduler that sequences the Montgomery multiplier datapath through one complete RSA modular exponentiation using left-to-right binary square-and-multiply.
- Generates the multiplier control strobes (enable, local clear, A-load, result-load, result-lock).
- Drives operand-select and write-back codes for the external operand register file: ACC, XM, constants ONE and R2.
- Sits between the host register interface (start/done) and the multiplier plus its operand muxes.

---
 rtl/rsa_pkg.sv | 52 +++++
 rtl/rsa_modexp_sched_call_seq.sv | 84 ++++++++
 rtl/rsa_modexp_sched.sv | 124 ++++++++++++
 tb/tb_rsa_modexp_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared encodings for the RSA modular-exponentiation scheduler: operand selects,
// write-back destinations, FSM states and the per-step operand mapping.
package rsa_pkg;

    localparam logic [1:0] SEL_ONE = 2'd0;
    localparam logic [1:0] SEL_R2  = 2'd1;
    localparam logic [1:0] SEL_ACC = 2'd2;
    localparam logic [1:0] SEL_XM  = 2'd3;

    localparam logic DST_ACC = 1'b0;
    localparam logic DST_XM  = 1'b1;

    typedef enum logic [2:0] {
        TOP_IDLE,
        TOP_TO_MONT,
        TOP_INIT_ACC,
        TOP_SQUARE,
        TOP_MULT,
        TOP_FROM_MONT,
        TOP_DONE
    } top_state_e;

    typedef enum logic [2:0] {
        CALL_IDLE,
        CALL_CLR,
        CALL_LOAD,
        CALL_RUN,
        CALL_CAPT,
        CALL_WB
    } call_state_e;

    typedef struct packed {
        logic [1:0] opa;
        logic [1:0] opb;
        logic       dst;
    } call_ops_t;

    // Operand/destination codes for the multiplication issued in each top state.
    function automatic call_ops_t ops_for(input top_state_e s);
        call_ops_t o;
        case (s)
            TOP_TO_MONT:   o = '{opa: SEL_XM,  opb: SEL_R2,  dst: DST_XM};
            TOP_INIT_ACC:  o = '{opa: SEL_ONE, opb: SEL_R2,  dst: DST_ACC};
            TOP_SQUARE:    o = '{opa: SEL_ACC, opb: SEL_ACC, dst: DST_ACC};
            TOP_MULT:      o = '{opa: SEL_ACC, opb: SEL_XM,  dst: DST_ACC};
            TOP_FROM_MONT: o = '{opa: SEL_ACC, opb: SEL_ONE, dst: DST_ACC};
            default:       o = '{opa: SEL_ONE, opb: SEL_ONE, dst: DST_ACC};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/rsa_modexp_sched_call_seq.sv
// Sequences one Montgomery multiplication: CLR, LOAD, RUN (MMM_CYCLES), CAPT, WB.
// A go seen during WB chains straight into the next CLR.
module mmm_call_seq
    import rsa_pkg::*;
#(
    parameter int MMM_CYCLES = 1026,
    parameter int CNT_W      = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic mmm_en,
    output logic mmm_rst_n,
    output logic mmm_ld_a,
    output logic mmm_ld_r,
    output logic mmm_lock,
    output logic res_we,
    output logic call_done
);

    call_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CALL_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CALL_IDLE: if (go) state_d = CALL_CLR;
            CALL_CLR:  state_d = CALL_LOAD;
            CALL_LOAD: begin
                state_d = CALL_RUN;
                cnt_d   = '0;
            end
            CALL_RUN: begin
                if (cnt_q == CNT_W'(MMM_CYCLES - 1)) begin
                    state_d = CALL_CAPT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CALL_CAPT: state_d = CALL_WB;
            CALL_WB:   state_d = go ? CALL_CLR : CALL_IDLE;
            default:   state_d = CALL_IDLE;
        endcase
    end

    always_comb begin
        mmm_en    = 1'b0;
        mmm_rst_n = 1'b1;
        mmm_ld_a  = 1'b0;
        mmm_ld_r  = 1'b0;
        mmm_lock  = 1'b1;
        res_we    = 1'b0;
        case (state_q)
            CALL_CLR:  mmm_rst_n = 1'b0;
            CALL_LOAD: begin
                mmm_en   = 1'b1;
                mmm_ld_a = 1'b1;
            end
            CALL_RUN:  mmm_en = 1'b1;
            CALL_CAPT: begin
                mmm_en   = 1'b1;
                mmm_ld_r = 1'b1;
                mmm_lock = 1'b0;
            end
            CALL_WB:   res_we = 1'b1;
            default:   ;
        endcase
    end

    assign call_done = (state_q == CALL_WB);

endmodule

// File: rtl/rsa_modexp_sched.sv
// Left-to-right square-and-multiply scheduler driving the Montgomery multiplier
// and the operand register file selects through one full modular exponentiation.
module rsa_modexp_sched
    import rsa_pkg::*;
#(
    parameter int MMM_CYCLES = 1026,
    parameter int EXP_BITS   = 1024,
    parameter int CNT_W      = 11,
    parameter int EXP_CNT_W  = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [EXP_BITS-1:0] exponent,
    output logic                busy,
    output logic                done,
    output logic                mmm_en,
    output logic                mmm_rst_n,
    output logic                mmm_ld_a,
    output logic                mmm_ld_r,
    output logic                mmm_lock,
    output logic [1:0]          opa_sel,
    output logic [1:0]          opb_sel,
    output logic                res_we,
    output logic                res_dst
);

    top_state_e           state_q, state_d;
    logic [EXP_CNT_W-1:0] idx_q, idx_d;
    call_ops_t            ops_q, ops_d;
    logic                 go;
    logic                 call_done;
    logic [EXP_BITS-1:0]  exp_sh;
    logic                 cur_bit;

    assign exp_sh  = exponent >> idx_q;
    assign cur_bit = exp_sh[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TOP_IDLE;
            idx_q   <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ops_q   <= ops_d;
        end
    end

    // go is issued in the same cycle the next step is chosen, so the selects
    // register together with the sequencer entering CLR.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        go      = 1'b0;
        case (state_q)
            TOP_IDLE: begin
                if (start) begin
                    state_d = TOP_TO_MONT;
                    go      = 1'b1;
                end
            end
            TOP_DONE: state_d = TOP_IDLE;
            default: begin
                if (call_done) begin
                    case (state_q)
                        TOP_TO_MONT:  state_d = TOP_INIT_ACC;
                        TOP_INIT_ACC: begin
                            state_d = TOP_SQUARE;
                            idx_d   = EXP_CNT_W'(EXP_BITS - 1);
                        end
                        TOP_SQUARE: begin
                            if (cur_bit) begin
                                state_d = TOP_MULT;
                            end else if (idx_q == '0) begin
                                state_d = TOP_FROM_MONT;
                            end else begin
                                idx_d = idx_q - EXP_CNT_W'(1);
                            end
                        end
                        TOP_MULT: begin
                            if (idx_q == '0) begin
                                state_d = TOP_FROM_MONT;
                            end else begin
                                state_d = TOP_SQUARE;
                                idx_d   = idx_q - EXP_CNT_W'(1);
                            end
                        end
                        default: state_d = TOP_DONE;
                    endcase
                    go = (state_d != TOP_DONE);
                end
            end
        endcase
        ops_d = ops_q;
        if (go || (state_d != state_q)) ops_d = ops_for(state_d);
    end

    always_comb begin
        busy    = (state_q != TOP_IDLE);
        done    = (state_q == TOP_DONE);
        opa_sel = ops_q.opa;
        opb_sel = ops_q.opb;
        res_dst = ops_q.dst;
    end

    mmm_call_seq #(
        .MMM_CYCLES(MMM_CYCLES),
        .CNT_W     (CNT_W)
    ) u_call_seq (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .mmm_en   (mmm_en),
        .mmm_rst_n(mmm_rst_n),
        .mmm_ld_a (mmm_ld_a),
        .mmm_ld_r (mmm_ld_r),
        .mmm_lock (mmm_lock),
        .res_we   (res_we),
        .call_done(call_done)
    );

endmodule

// File: tb/tb_rsa_modexp_sched.sv
// Scoreboard bench for rsa_modexp_sched: a square-and-multiply call list plus a
// per-cycle strobe timeline model, with a monitor popping expectations on res_we/done.
module tb_rsa_modexp_sched;
    import rsa_pkg::*;

    localparam int MMM = 4;
    localparam int EB  = 4;
    localparam int L   = MMM + 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [EB-1:0] exponent = '0;
    logic          busy, done, mmm_en, mmm_rst_n, mmm_ld_a, mmm_ld_r, mmm_lock;
    logic [1:0]    opa_sel, opb_sel;
    logic          res_we, res_dst;

    rsa_modexp_sched #(
        .MMM_CYCLES(MMM),
        .EXP_BITS  (EB),
        .CNT_W     (11),
        .EXP_CNT_W (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .exponent (exponent),
        .busy     (busy),
        .done     (done),
        .mmm_en   (mmm_en),
        .mmm_rst_n(mmm_rst_n),
        .mmm_ld_a (mmm_ld_a),
        .mmm_ld_r (mmm_ld_r),
        .mmm_lock (mmm_lock),
        .opa_sel  (opa_sel),
        .opb_sel  (opb_sel),
        .res_we   (res_we),
        .res_dst  (res_dst)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] opa;
        logic [1:0] opb;
        logic       dst;
    } call_t;

    call_t op_calls[$];
    call_t sb_calls[$];
    int    sb_done[$];
    int    op_start = 0;
    int    op_abort = 32'h7fffffff;
    bit    op_valid = 1'b0;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Timeline: each call is L cycles (CLR, LOAD, MMM x RUN, CAPT, WB), then one DONE cycle.
    function automatic logic [12:0] expected_vec();
        logic       b, d, en, rn, la, lr, lk, we, dst;
        logic [1:0] a, bb;
        int         j, k, p, n;
        b = 0; d = 0; en = 0; rn = 1; la = 0; lr = 0; lk = 1; we = 0; a = 0; bb = 0; dst = 0;
        if (op_valid && cyc >= op_start && cyc < op_abort) begin
            n = op_calls.size();
            j = cyc - op_start + 1;
            if (j <= n * L) begin
                k   = (j - 1) / L;
                p   = (j - 1) % L;
                b   = 1;
                rn  = (p != 0);
                la  = (p == 1);
                en  = (p >= 1 && p <= MMM + 2);
                lr  = (p == MMM + 2);
                lk  = !lr;
                we  = (p == MMM + 3);
                a   = op_calls[k].opa;
                bb  = op_calls[k].opb;
                dst = op_calls[k].dst;
            end else if (j == n * L + 1) begin
                b = 1;
                d = 1;
            end
        end
        return {b, d, en, rn, la, lr, lk, we, a, bb, dst};
    endfunction

    always @(posedge clk) begin
        call_t c;
        int    dc;
        #1;
        chk("outputs{busy,done,en,rst_n,ld_a,ld_r,lock,we,opa,opb,dst}",
            {busy, done, mmm_en, mmm_rst_n, mmm_ld_a, mmm_ld_r, mmm_lock, res_we,
             opa_sel, opb_sel, res_dst},
            expected_vec());
        if (res_we === 1'b1) begin
            chk("res_we_expected", sb_calls.size() != 0, 1);
            if (sb_calls.size() != 0) begin
                c = sb_calls.pop_front();
                chk("call_wb_cycle", cyc, c.cyc);
                chk("call_ops", {opa_sel, opb_sel, res_dst}, {c.opa, c.opb, c.dst});
            end
        end
        if (done === 1'b1) begin
            chk("done_expected", sb_done.size() != 0, 1);
            if (sb_done.size() != 0) begin
                dc = sb_done.pop_front();
                chk("done_cycle", cyc, dc);
            end
        end
    end

    function automatic void add_call(input logic [1:0] a, input logic [1:0] b, input logic d);
        call_t c;
        c.cyc = 0; c.opa = a; c.opb = b; c.dst = d;
        op_calls.push_back(c);
    endfunction

    task automatic launch(input logic [EB-1:0] e, output int s);
        call_t c;
        @(negedge clk);
        exponent = e;
        start    = 1'b1;
        s        = cyc + 1;
        op_calls.delete();
        add_call(SEL_XM, SEL_R2, DST_XM);
        add_call(SEL_ONE, SEL_R2, DST_ACC);
        for (int i = EB - 1; i >= 0; i--) begin
            add_call(SEL_ACC, SEL_ACC, DST_ACC);
            if (e[i]) add_call(SEL_ACC, SEL_XM, DST_ACC);
        end
        add_call(SEL_ACC, SEL_ONE, DST_ACC);
        for (int k = 0; k < op_calls.size(); k++) begin
            c     = op_calls[k];
            c.cyc = s + k * L + L - 1;
            sb_calls.push_back(c);
        end
        sb_done.push_back(s + op_calls.size() * L);
        op_start = s;
        op_abort = 32'h7fffffff;
        op_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_op(input int s);
        while (cyc < s + op_calls.size() * L + 2) @(negedge clk);
        chk("done_seen", sb_done.size(), 0);
        chk("calls_seen", sb_calls.size(), 0);
    endtask

    initial begin
        int s;
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        launch(4'b1011, s);
        chk("calls_1011", op_calls.size(), 10);
        finish_op(s);

        launch(4'b0000, s);
        chk("calls_0000", op_calls.size(), 7);
        finish_op(s);

        // Starts while busy and during the DONE cycle must be ignored.
        launch(4'b1111, s);
        chk("calls_1111", op_calls.size(), 11);
        n = op_calls.size();
        while (cyc < s + 39) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + n * L) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op(s);
        repeat (3) @(negedge clk);

        for (int r = 0; r < 3; r++) begin
            launch(EB'($urandom_range(0, 15)), s);
            finish_op(s);
        end

        // Abort during RUN of the third call, then a fresh run completes.
        launch(4'b1011, s);
        while (cyc < s + 19) @(negedge clk);
        rst      = 1'b1;
        op_abort = cyc + 1;
        @(negedge clk);
        rst = 1'b0;
        sb_calls.delete();
        sb_done.delete();
        repeat (L * 3) @(negedge clk);
        op_valid = 1'b0;
        repeat (2) @(negedge clk);

        launch(4'b0110, s);
        finish_op(s);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
